// File: rtl/irq_collector_pkg.sv
// -----------------------------------------------------------------------------
// mopshub_irq_pkg
// Shared constants for the interrupt collector slice.
//   MAX_CH     : largest supported channel count
//   ID_W       : width of the winning-channel index
//   CNT_W      : width of the pending-channel count (holds 0..MAX_CH)
//   MODE_LEVEL : latch channels while their line is high
//   MODE_EDGE  : latch channels on a rising edge of their line
// -----------------------------------------------------------------------------
package mopshub_irq_pkg;

  localparam int MAX_CH     = 32;
  localparam int ID_W       = 5;
  localparam int CNT_W      = 6;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_EDGE  = 1;

endpackage : mopshub_irq_pkg

// File: rtl/irq_collector_if.sv
// -----------------------------------------------------------------------------
// irq_collector_if
// Channel-request / read-and-clear bundle of the interrupt collector.
//   irq_in     : raw channel request lines
//   mask       : per-channel mask, 1 = masked
//   rd_req     : read-and-clear request
//   rd_ack     : one-cycle acknowledge of an accepted read
//   status_out : pending snapshot taken by the last read
//   ovr_out    : overrun snapshot taken by the last read
//   irq        : any unmasked channel pending
//   irq_id     : lowest unmasked pending channel
//   pend_cnt   : number of unmasked pending channels
// master = request side (drives lines, issues reads), slave = the collector.
// -----------------------------------------------------------------------------
interface irq_collector_if #(
  parameter int N_CH  = 16,
  parameter int BUS_W = 32
);
  import mopshub_irq_pkg::*;

  logic [N_CH-1:0]  irq_in;
  logic [N_CH-1:0]  mask;
  logic             rd_req;
  logic             rd_ack;
  logic [BUS_W-1:0] status_out;
  logic [BUS_W-1:0] ovr_out;
  logic             irq;
  logic [ID_W-1:0]  irq_id;
  logic [CNT_W-1:0] pend_cnt;

  modport master (
    output irq_in, mask, rd_req,
    input  rd_ack, status_out, ovr_out, irq, irq_id, pend_cnt
  );

  modport slave (
    input  irq_in, mask, rd_req,
    output rd_ack, status_out, ovr_out, irq, irq_id, pend_cnt
  );

endinterface : irq_collector_if

// File: rtl/irq_collector_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Lowest-index priority encoder plus population count over a request vector.
//   i_vec : request vector (already masked by the caller)
//   o_any : OR of i_vec
//   o_id  : index of the lowest set bit, 0 when none
//   o_cnt : number of set bits
// -----------------------------------------------------------------------------
module irq_prio_enc
  import mopshub_irq_pkg::*;
#(
  parameter int N_CH = 16
) (
  input  logic [N_CH-1:0]  i_vec,
  output logic             o_any,
  output logic [ID_W-1:0]  o_id,
  output logic [CNT_W-1:0] o_cnt
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would infer a latch.
    o_any = |i_vec;
    o_id  = '0;
    o_cnt = '0;
    // Scan high to low so the last hit, the lowest index, wins.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_id = ID_W'(i);
      end
      o_cnt = o_cnt + CNT_W'(i_vec[i]);
    end
  end

endmodule : irq_prio_enc

// File: rtl/irq_collector.sv
// -----------------------------------------------------------------------------
// irq_collector
// Collects per-channel interrupt events into sticky pending bits, flags
// channels that fire again while still pending (overrun), and offers an
// atomic read-and-clear that snapshots both vectors.
//   clk  : clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : irq_collector_if.slave (request lines, mask, read handshake,
//          snapshots and the combinational irq / irq_id / pend_cnt summary)
// Parameters: N_CH channels (1..32), BUS_W snapshot width (>= N_CH),
//             EDGE_MODE 1 = rising-edge events, 0 = level events.
// -----------------------------------------------------------------------------
module irq_collector
  import mopshub_irq_pkg::*;
#(
  parameter int N_CH      = 16,
  parameter int BUS_W     = 32,
  parameter int EDGE_MODE = MODE_EDGE
) (
  input  logic          clk,
  input  logic          rst,
  irq_collector_if.slave bus
);

  logic [N_CH-1:0] r_in_q;
  logic [N_CH-1:0] r_in_qq;
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] r_ovr;
  logic [N_CH-1:0] r_status;
  logic [N_CH-1:0] r_ovr_snap;
  logic            r_rd_ack;

  logic [N_CH-1:0]  w_prev;
  logic [N_CH-1:0]  w_event;
  logic [N_CH-1:0]  w_set;
  logic [N_CH-1:0]  w_active;
  logic [BUS_W-1:0] w_status_pad;
  logic [BUS_W-1:0] w_ovr_pad;

  // In level mode the previous sample is ignored, so an event is simply the
  // registered line; in edge mode it is a 0->1 transition between samples.
  assign w_prev   = (EDGE_MODE == MODE_EDGE) ? r_in_qq : '0;
  assign w_event  = r_in_q & ~w_prev;
  // Masked events are dropped outright, not held back for later.
  assign w_set    = w_event & ~bus.mask;
  // Masking hides a pending bit from the summary without clearing it.
  assign w_active = r_pending & ~bus.mask;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, which the read-and-clear swap relies on.
    if (!rst) begin
      r_in_q     <= '0;
      r_in_qq    <= '0;
      r_pending  <= '0;
      r_ovr      <= '0;
      r_status   <= '0;
      r_ovr_snap <= '0;
      r_rd_ack   <= 1'b0;
    end else begin
      r_in_q   <= bus.irq_in;
      r_in_qq  <= r_in_q;
      r_rd_ack <= bus.rd_req;
      if (bus.rd_req) begin
        // Snapshot and clear in one edge; events landing on this edge seed
        // the fresh pending vector so none are lost across the read.
        r_status   <= r_pending;
        r_ovr_snap <= r_ovr;
        r_pending  <= w_set;
        r_ovr      <= '0;
      end else begin
        r_pending  <= r_pending | w_set;
        r_ovr      <= r_ovr | (w_set & r_pending);
      end
    end
  end

  // Zero-extend the snapshots onto the wider bus; written as a default plus
  // a slice so BUS_W == N_CH needs no zero-width replication.
  always_comb begin
    w_status_pad           = '0;
    w_status_pad[N_CH-1:0] = r_status;
    w_ovr_pad              = '0;
    w_ovr_pad[N_CH-1:0]    = r_ovr_snap;
  end

  assign bus.status_out = w_status_pad;
  assign bus.ovr_out    = w_ovr_pad;
  assign bus.rd_ack     = r_rd_ack;

  irq_prio_enc #(
    .N_CH (N_CH)
  ) u_prio_enc (
    .i_vec (w_active),
    .o_any (bus.irq),
    .o_id  (bus.irq_id),
    .o_cnt (bus.pend_cnt)
  );

endmodule : irq_collector

// File: tb/tb_irq_collector.sv
// -----------------------------------------------------------------------------
// tb_irq_collector
// Directed bench for irq_collector: one edge-mode instance and one level-mode
// instance (both N_CH=16, BUS_W=32) sharing clock and reset. Inputs are
// driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_irq_collector;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  irq_collector_if #(.N_CH(16), .BUS_W(32)) bus_e ();
  irq_collector_if #(.N_CH(16), .BUS_W(32)) bus_l ();

  irq_collector #(.N_CH(16), .BUS_W(32), .EDGE_MODE(1)) u_dut_edge (
    .clk (clk),
    .rst (rst),
    .bus (bus_e.slave)
  );

  irq_collector #(.N_CH(16), .BUS_W(32), .EDGE_MODE(0)) u_dut_level (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on the edge instance; the bits are pending afterwards.
  task automatic pulse(input logic [15:0] v);
    bus_e.irq_in = v;
    tick();
    bus_e.irq_in = '0;
    tick();
  endtask

  task automatic do_read();
    bus_e.rd_req = 1'b1;
    tick();
    bus_e.rd_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b0;
    bus_e.irq_in = '0;
    bus_e.mask   = '0;
    bus_e.rd_req = 1'b0;
    bus_l.irq_in = '0;
    bus_l.mask   = '0;
    bus_l.rd_req = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ack",    32'(bus_e.rd_ack),   32'd0);
    check("rst_status", bus_e.status_out,    32'd0);
    check("rst_ovr",    bus_e.ovr_out,       32'd0);
    check("rst_irq",    32'(bus_e.irq),      32'd0);
    check("rst_id",     32'(bus_e.irq_id),   32'd0);
    check("rst_cnt",    32'(bus_e.pend_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // Rising edge on channel 3, held high
    bus_e.irq_in = 16'h0008;
    tick();
    check("a_latency_irq", 32'(bus_e.irq), 32'd0);
    tick();
    check("a_irq", 32'(bus_e.irq),      32'd1);
    check("a_id",  32'(bus_e.irq_id),   32'd3);
    check("a_cnt", 32'(bus_e.pend_cnt), 32'd1);
    repeat (3) tick();
    check("a_held_cnt", 32'(bus_e.pend_cnt), 32'd1);
    do_read();
    check("a_ack",    32'(bus_e.rd_ack), 32'd1);
    check("a_status", bus_e.status_out,  32'h0000_0008);
    check("a_no_ovr", bus_e.ovr_out,     32'h0000_0000);
    check("a_cleared_irq", 32'(bus_e.irq), 32'd0);
    tick();
    check("a_ack_drop", 32'(bus_e.rd_ack), 32'd0);
    bus_e.irq_in = '0;
    tick();

    // Channels 5 and 9 then a read
    pulse(16'h0220);
    check("b_id",  32'(bus_e.irq_id),   32'd5);
    check("b_cnt", 32'(bus_e.pend_cnt), 32'd2);
    do_read();
    check("b_ack",    32'(bus_e.rd_ack), 32'd1);
    check("b_status", bus_e.status_out,  32'h0000_0220);
    check("b_irq",    32'(bus_e.irq),    32'd0);
    tick();
    check("b_ack_drop",    32'(bus_e.rd_ack), 32'd0);
    check("b_status_hold", bus_e.status_out,  32'h0000_0220);

    // Back-to-back reads give back-to-back acks
    bus_e.rd_req = 1'b1;
    tick();
    check("bb_ack1", 32'(bus_e.rd_ack), 32'd1);
    tick();
    check("bb_ack2",   32'(bus_e.rd_ack), 32'd1);
    check("bb_status", bus_e.status_out,  32'h0000_0000);
    bus_e.rd_req = 1'b0;
    tick();
    check("bb_ack_drop", 32'(bus_e.rd_ack), 32'd0);

    // Overrun on channel 2
    pulse(16'h0004);
    pulse(16'h0004);
    check("c_cnt", 32'(bus_e.pend_cnt), 32'd1);
    do_read();
    check("c_status", bus_e.status_out, 32'h0000_0004);
    check("c_ovr",    bus_e.ovr_out,    32'h0000_0004);
    do_read();
    check("c_status2", bus_e.status_out, 32'h0000_0000);
    check("c_ovr2",    bus_e.ovr_out,    32'h0000_0000);

    // Channel 7 event on the same edge as a read
    pulse(16'h0002);
    bus_e.irq_in = 16'h0080;
    tick();
    bus_e.irq_in = '0;
    bus_e.rd_req = 1'b1;
    tick();
    check("d_ack",    32'(bus_e.rd_ack), 32'd1);
    check("d_status", bus_e.status_out,  32'h0000_0002);
    check("d_irq",    32'(bus_e.irq),    32'd1);
    check("d_id",     32'(bus_e.irq_id), 32'd7);
    tick();
    bus_e.rd_req = 1'b0;
    check("d_status2", bus_e.status_out, 32'h0000_0080);
    check("d_irq2",    32'(bus_e.irq),   32'd0);

    // Masking: discarded events, and masking an already-pending bit
    bus_e.mask = 16'h0001;
    pulse(16'h0001);
    check("e_masked_irq", 32'(bus_e.irq),      32'd0);
    check("e_masked_cnt", 32'(bus_e.pend_cnt), 32'd0);
    bus_e.mask = 16'h0000;
    #1;
    check("e_discarded", 32'(bus_e.irq), 32'd0);
    pulse(16'h0010);
    check("e_irq4", 32'(bus_e.irq),    32'd1);
    check("e_id4",  32'(bus_e.irq_id), 32'd4);
    bus_e.mask = 16'h0010;
    #1;
    check("e_hidden_irq", 32'(bus_e.irq),      32'd0);
    check("e_hidden_cnt", 32'(bus_e.pend_cnt), 32'd0);
    check("e_hidden_id",  32'(bus_e.irq_id),   32'd0);
    do_read();
    check("e_status", bus_e.status_out, 32'h0000_0010);
    bus_e.mask = 16'h0000;

    // Priority: lowest of 10, 11, 15
    pulse(16'h8C00);
    check("f_id",  32'(bus_e.irq_id),   32'd10);
    check("f_cnt", 32'(bus_e.pend_cnt), 32'd3);
    do_read();
    check("f_status", bus_e.status_out, 32'h0000_8C00);

    // Reset overrides a read; line 0 held high across reset release
    pulse(16'h0040);
    bus_e.irq_in = 16'h0001;
    bus_e.rd_req = 1'b1;
    rst = 1'b0;
    tick();
    bus_e.rd_req = 1'b0;
    rst = 1'b1;
    check("g_ack",    32'(bus_e.rd_ack), 32'd0);
    check("g_status", bus_e.status_out,  32'h0000_0000);
    check("g_irq",    32'(bus_e.irq),    32'd0);
    tick();
    check("g_ack_after", 32'(bus_e.rd_ack), 32'd0);
    tick();
    check("g_edge_irq", 32'(bus_e.irq),      32'd1);
    check("g_edge_cnt", 32'(bus_e.pend_cnt), 32'd1);
    do_read();
    check("g_status2", bus_e.status_out, 32'h0000_0001);
    repeat (3) tick();
    check("g_one_edge", 32'(bus_e.irq), 32'd0);
    bus_e.irq_in = '0;

    // Level mode: lines held through reset, then reads
    bus_l.irq_in = 16'h8001;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("h_irq", 32'(bus_l.irq),      32'd1);
    check("h_cnt", 32'(bus_l.pend_cnt), 32'd2);
    bus_l.rd_req = 1'b1;
    tick();
    check("h_ack",    32'(bus_l.rd_ack), 32'd1);
    check("h_status", bus_l.status_out,  32'h0000_8001);
    check("h_ovr",    bus_l.ovr_out,     32'h0000_8001);
    tick();
    bus_l.rd_req = 1'b0;
    check("h_status2", bus_l.status_out,  32'h0000_8001);
    check("h_ovr2",    bus_l.ovr_out,     32'h0000_0000);
    check("h_reset_irq", 32'(bus_l.irq),  32'd1);
    check("h_reset_cnt", 32'(bus_l.pend_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_irq_collector
